// File: rtl/parity_seq_ctrl.sv
// Word parity sequencer: streams a WIDTH-bit word, 3 bits per cycle, through one
// external 3-input parity generator and returns the word with its parity bit.
module parity_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             odd_mode,
    output logic             pg_A,
    output logic             pg_B,
    output logic             pg_C,
    input  logic             pg_Even,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             parity_bit,
    output logic             busy
);

    localparam int NCHUNK = (WIDTH + 2) / 3;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PW     = 3 * NCHUNK;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             acc_q, acc_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             mode_q, mode_d;

    logic [PW-1:0]    padded;
    logic [2:0]       chunk;
    logic             last_chunk;

    // Zero-pad the word up to a whole number of chunks so the top chunk reads 0s.
    always_comb begin
        padded = '0;
        padded[WIDTH-1:0] = word_q;
        chunk = 3'b000;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IW'(k)) chunk = padded[3*k +: 3];
        end
    end

    assign last_chunk = (idx_q == IW'(NCHUNK - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        word_d  = word_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    word_d  = data_in;
                    mode_d  = odd_mode;
                    acc_d   = 1'b0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_q ^ pg_Even;
                if (last_chunk) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            acc_q   <= 1'b0;
            word_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            word_q  <= word_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE) && !rst;
    assign busy       = (state_q == S_RUN) || (state_q == S_DONE);
    assign out_valid  = (state_q == S_DONE);
    assign {pg_A, pg_B, pg_C} = (state_q == S_RUN) ? chunk : 3'b000;
    assign data_out   = word_q;
    assign parity_bit = (state_q == S_DONE) ? (acc_q ^ mode_q) : 1'b0;

endmodule

// File: tb/tb_parity_seq_ctrl.sv
// Directed bench for parity_seq_ctrl: WIDTH=8 main instance plus a WIDTH=4 instance,
// each paired with an XOR3 model of the external parity generator.
module tb_parity_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, odd_mode = 1'b0, out_ready = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       in_ready, pg_A, pg_B, pg_C, pg_Even, out_valid, parity_bit, busy;
    logic [7:0] data_out;

    logic       in_valid4 = 1'b0, odd_mode4 = 1'b0, out_ready4 = 1'b0;
    logic [3:0] data_in4 = 4'h0;
    logic       in_ready4, pg_A4, pg_B4, pg_C4, pg_Even4, out_valid4, parity_bit4, busy4;
    logic [3:0] data_out4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign pg_Even  = pg_A ^ pg_B ^ pg_C;
    assign pg_Even4 = pg_A4 ^ pg_B4 ^ pg_C4;

    parity_seq_ctrl #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .odd_mode(odd_mode), .pg_A(pg_A), .pg_B(pg_B),
        .pg_C(pg_C), .pg_Even(pg_Even), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .parity_bit(parity_bit),
        .busy(busy)
    );

    parity_seq_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .data_in(data_in4), .odd_mode(odd_mode4), .pg_A(pg_A4), .pg_B(pg_B4),
        .pg_C(pg_C4), .pg_Even(pg_Even4), .out_valid(out_valid4),
        .out_ready(out_ready4), .data_out(data_out4), .parity_bit(parity_bit4),
        .busy(busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({out_valid, busy, pg_A, pg_B, pg_C, parity_bit} !== 6'b0 || data_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outs: ov/busy/pg/par=%b data_out=%h, required 000000 / 00",
                     {out_valid, busy, pg_A, pg_B, pg_C, parity_bit}, data_out);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || in_ready4 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b/%b, required 1/1", in_ready, in_ready4);
        end
    endtask

    // Accept one word, walk the RUN chunks, check DONE outputs and return to IDLE.
    task automatic test_word(input logic [7:0] d, input logic odd,
                             input logic [8:0] exp_pg, input logic exp_par);
        data_in = d; odd_mode = odd; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        data_in  = ~d;
        odd_mode = ~odd;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({pg_A, pg_B, pg_C} !== exp_pg[8-3*k -: 3] || busy !== 1'b1 ||
                in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL run_chunk%0d word=%h: pg=%b busy=%b ir=%b ov=%b, required pg=%b busy=1 ir=0 ov=0",
                         k, d, {pg_A, pg_B, pg_C}, busy, in_ready, out_valid, exp_pg[8-3*k -: 3]);
            end
            tick();
        end
        n_cmp++;
        if (out_valid !== 1'b1 || data_out !== d || parity_bit !== exp_par ||
            {pg_A, pg_B, pg_C} !== 3'b000) begin
            n_bad++;
            $display("FAIL done word=%h odd=%b: ov=%b data_out=%h par=%b pg=%b, required ov=1 %h par=%b pg=000",
                     d, odd, out_valid, data_out, parity_bit, {pg_A, pg_B, pg_C}, d, exp_par);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL back_idle word=%h: ov=%b ir=%b busy=%b, required 0 1 0",
                     d, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_backpressure();
        data_in = 8'hFF; odd_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        for (int c = 0; c < 5; c++) begin
            data_in  = 8'h01;
            in_valid = c[0];
            n_cmp++;
            if (out_valid !== 1'b1 || data_out !== 8'hFF || parity_bit !== 1'b0 ||
                in_ready !== 1'b0 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL bp_hold cyc%0d: ov=%b data_out=%h par=%b ir=%b busy=%b, required 1 ff 0 0 1",
                         c, out_valid, data_out, parity_bit, in_ready, busy);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (out_valid !== 1'b1 || data_out !== 8'hFF) begin
            n_bad++;
            $display("FAIL bp_release_pre: ov=%b data_out=%h, required 1 ff", out_valid, data_out);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_idle: ov=%b ir=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int acc_cyc[4];
        logic [7:0] od[4];
        logic op[4];
        int na = 0;
        int no = 0;
        data_in = 8'h01; odd_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (in_valid && in_ready && na < 4) begin acc_cyc[na] = c; na++; end
            if (out_valid && out_ready && no < 4) begin
                od[no] = data_out; op[no] = parity_bit; no++;
            end
            tick();
            if (na == 1) data_in = 8'h03;
            if (na >= 2) in_valid = 1'b0;
        end
        n_cmp++;
        if (na !== 2 || no !== 2) begin
            n_bad++;
            $display("FAIL b2b_counts: accepts=%0d outputs=%0d, required 2 2", na, no);
        end else begin
            n_cmp++;
            if (acc_cyc[1] - acc_cyc[0] != 5) begin
                n_bad++;
                $display("FAIL b2b_spacing: %0d cycles, required 5", acc_cyc[1] - acc_cyc[0]);
            end
            n_cmp++;
            if (od[0] !== 8'h01 || op[0] !== 1'b1 || od[1] !== 8'h03 || op[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_results: %h/%b then %h/%b, required 01/1 then 03/0",
                         od[0], op[0], od[1], op[1]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        data_in = 8'hA5; odd_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if ({pg_A, pg_B, pg_C} !== 3'b100 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pre idx1: pg=%b busy=%b, required 100 1", {pg_A, pg_B, pg_C}, busy);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, busy, pg_A, pg_B, pg_C} !== 5'b0) begin
            n_bad++;
            $display("FAIL rst_abort: ov/busy/pg=%b, required 00000", {out_valid, busy, pg_A, pg_B, pg_C});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_release in_ready: got %b, required 1", in_ready);
        end
        data_in = 8'h80; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (out_valid !== 1'b1 || data_out !== 8'h80 || parity_bit !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_next_word: ov=%b data_out=%h par=%b, required 1 80 1",
                     out_valid, data_out, parity_bit);
        end
        tick();
    endtask

    task automatic test_width4();
        logic [5:0] exp_pg;
        exp_pg = 6'b011_001;
        data_in4 = 4'hB; odd_mode4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({pg_A4, pg_B4, pg_C4} !== exp_pg[5-3*k -: 3] || busy4 !== 1'b1) begin
                n_bad++;
                $display("FAIL w4_chunk%0d: pg=%b busy=%b, required %b 1",
                         k, {pg_A4, pg_B4, pg_C4}, busy4, exp_pg[5-3*k -: 3]);
            end
            tick();
        end
        n_cmp++;
        if (out_valid4 !== 1'b1 || data_out4 !== 4'hB || parity_bit4 !== 1'b1) begin
            n_bad++;
            $display("FAIL w4_done: ov=%b data_out=%h par=%b, required 1 b 1",
                     out_valid4, data_out4, parity_bit4);
        end
        tick();
    endtask

    initial begin
        test_reset();
        tick();
        test_word(8'hA5, 1'b0, 9'b101_100_010, 1'b0);
        test_word(8'hA5, 1'b1, 9'b101_100_010, 1'b1);
        test_word(8'h07, 1'b0, 9'b111_000_000, 1'b1);
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_width4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
